// File: rtl/pe_stream_feeder_pkg.sv
// rtl/pe_stream_feeder_pkg.sv - fixed-point defaults, sign-magnitude conversions and feeder states
package pe_stream_feeder_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 19;

  // One guard bit above the word keeps the sum of two saturated terms exact.
  typedef logic signed [N_DEF:0] acc_t;

  localparam acc_t SAT_POS = {2'b00, {(N_DEF-1){1'b1}}};
  localparam acc_t SAT_NEG = -SAT_POS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // -0 maps to 0 because negating a zero magnitude is still zero.
  function automatic acc_t sm_to_tc(input logic [N_DEF-1:0] x);
    acc_t mag;
    mag = {2'b00, x[N_DEF-2:0]};
    return x[N_DEF-1] ? -mag : mag;
  endfunction

  // Input must already lie within the saturation limits; a negative value is
  // always nonzero, so -0 can never be produced.
  function automatic logic [N_DEF-1:0] tc_to_sm(input acc_t v);
    acc_t mag;
    mag = v[N_DEF] ? -v : v;
    return {v[N_DEF], (N_DEF-1)'(mag)};
  endfunction

endpackage

// File: rtl/pe_stream_feeder_if.sv
// rtl/pe_stream_feeder_if.sv - two-input processing-element bus between feeder and PE
interface pe_stream_feeder_if
  import pe_stream_feeder_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         pe_en;
  logic [N-1:0] pe_in1;
  logic [N-1:0] pe_in2;
  logic [N-1:0] pe_w1;
  logic [N-1:0] pe_w2;
  logic [N-1:0] pe_out;

  modport master (output pe_en, pe_in1, pe_in2, pe_w1, pe_w2, input pe_out);
  modport slave  (input pe_en, pe_in1, pe_in2, pe_w1, pe_w2, output pe_out);

endinterface

// File: rtl/pe_stream_feeder_lat_tracker.sv
// rtl/pe_stream_feeder_lat_tracker.sv - valid shift register mirroring the PE pipeline depth
module pe_lat_tracker #(
  parameter int PE_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tail,
  output logic empty
);

  localparam logic [PE_LAT-1:0] TAIL_BIT = PE_LAT'(1) << (PE_LAT - 1);

  logic [PE_LAT-1:0] vld;

  // Shift one valid bit per issued pair; the top bit lines up with pe_out.
  always_ff @(posedge clk) begin
    if (!rst) vld <= '0;
    else      vld <= (vld << 1) | PE_LAT'(en);
  end

  assign tail  = vld[PE_LAT-1];
  // Nothing is in flight behind the tail stage.
  assign empty = (vld & ~TAIL_BIT) == '0;

endmodule

// File: rtl/pe_stream_feeder.sv
// rtl/pe_stream_feeder.sv - buffers vectors, issues pairs to a PE and accumulates a saturated dot product
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Q      = Q_DEF,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int PE_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [N-1:0]           wr_in,
  input  logic [N-1:0]           wr_w,
  input  logic [AW-1:0]          len,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           result,
  output logic                   ovf,
  pe_stream_feeder_if.master     pe
);

  if (N != N_DEF || Q >= N || DEPTH < 2 || (DEPTH % 2) != 0 || PE_LAT < 1) begin : g_param_check
    $error("pe_stream_feeder: unsupported parameter set");
  end

  state_t        state, state_next;
  logic [N-1:0]  mem_in [DEPTH];
  logic [N-1:0]  mem_w  [DEPTH];
  logic [AW-1:0] len_q, issued, idx, addr_even, addr_odd;
  logic          accept, issue_now, cap, upstream_empty, sat;
  acc_t          acc, sum, acc_next;

  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign accept    = (state == ST_IDLE) && start;
  // Pair 0 goes out on the accepting edge, so the first pe_en follows start by one cycle.
  assign idx       = (state == ST_IDLE) ? '0 : issued;
  assign addr_even = idx << 1;
  assign addr_odd  = addr_even | AW'(1);
  assign issue_now = accept || ((state == ST_ISSUE) && (issued != len_q));

  pe_lat_tracker #(.PE_LAT(PE_LAT)) u_lat (
    .clk   (clk),
    .rst   (rst),
    .en    (pe.pe_en),
    .tail  (cap),
    .empty (upstream_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state: leave DRAIN on the edge that captures the final partial sum.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ISSUE;
      ST_ISSUE: if (issued == len_q) state_next = ST_DRAIN;
      ST_DRAIN: if (cap && upstream_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Vector buffers; writable only while not running, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en && !busy) begin
      mem_in[wr_addr] <= wr_in;
      mem_w[wr_addr]  <= wr_w;
    end
  end

  // Issue path: registered PE strobe and operands, zeroed between pairs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pe.pe_en  <= 1'b0;
      pe.pe_in1 <= '0;
      pe.pe_in2 <= '0;
      pe.pe_w1  <= '0;
      pe.pe_w2  <= '0;
      issued    <= '0;
      len_q     <= '0;
    end else begin
      pe.pe_en <= issue_now;
      if (issue_now) begin
        pe.pe_in1 <= mem_in[addr_even];
        pe.pe_in2 <= mem_in[addr_odd];
        pe.pe_w1  <= mem_w[addr_even];
        pe.pe_w2  <= mem_w[addr_odd];
        issued    <= idx + AW'(1);
      end else begin
        pe.pe_in1 <= '0;
        pe.pe_in2 <= '0;
        pe.pe_w1  <= '0;
        pe.pe_w2  <= '0;
      end
      if (accept) len_q <= (len == '0) ? AW'(1) : len;
    end
  end

  // Saturating add of the returning partial sum.
  always_comb begin
    sum      = acc + sm_to_tc(pe.pe_out);
    acc_next = sum;
    sat      = 1'b0;
    if (sum > SAT_POS) begin
      acc_next = SAT_POS;
      sat      = 1'b1;
    end else if (sum < SAT_NEG) begin
      acc_next = SAT_NEG;
      sat      = 1'b1;
    end
  end

  // Accumulator, sticky overflow and the published result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc    <= '0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (cap) begin
        acc <= acc_next;
        if (sat) ovf <= 1'b1;
      end
      if ((state == ST_DRAIN) && (state_next == ST_DONE)) result <= tc_to_sm(acc_next);
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb/tb_pe_stream_feeder.sv - directed table-driven bench for pe_stream_feeder with a PE model
module tb_pe_stream_feeder;

  localparam int AW     = 4;
  localparam int PE_LAT = 3;
  localparam int QB     = 19;

  localparam logic [31:0] ONE    = 32'h0008_0000;
  localparam logic [31:0] TWO    = 32'h0010_0000;
  localparam logic [31:0] HALF   = 32'h0004_0000;
  localparam logic [31:0] PI     = 32'h0019_21FB;
  localparam logic [31:0] NTWO   = 32'h8010_0000;
  localparam logic [31:0] NTHREE = 32'h8018_0000;
  localparam logic [31:0] MAXV   = 32'h7FFF_FFFF;
  localparam logic [31:0] NMAXV  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_in, wr_w;
  logic [AW-1:0] len;
  logic          start;
  logic          busy, done, ovf;
  logic [31:0]   result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pe_stream_feeder_if #(.N(32)) pe_bus ();

  pe_stream_feeder #(.N(32), .Q(QB), .DEPTH(16), .AW(AW), .PE_LAT(PE_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_in   (wr_in),
    .wr_w    (wr_w),
    .len     (len),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .pe      (pe_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sm2int(input logic [31:0] a);
    longint m;
    m = {33'b0, a[30:0]};
    return a[31] ? -m : m;
  endfunction

  // Reference PE: Q19 dot product of the pair, truncated magnitude, sign kept (can yield -0).
  function automatic logic [31:0] pe_model(input logic [31:0] a1, a2, b1, b2);
    longint p, m;
    p = sm2int(a1) * sm2int(b1) + sm2int(a2) * sm2int(b2);
    m = (p < 0) ? -p : p;
    m = m >> QB;
    if (m > 64'h7FFF_FFFF) m = 64'h7FFF_FFFF;
    return {(p < 0), m[30:0]};
  endfunction

  logic [31:0] pe_pipe [0:PE_LAT-1];
  always @(posedge clk) begin
    pe_pipe[0] <= pe_bus.pe_en ? pe_model(pe_bus.pe_in1, pe_bus.pe_in2, pe_bus.pe_w1, pe_bus.pe_w2)
                               : 32'h5A5A_5A5A;
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_bus.pe_out = pe_pipe[PE_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a1, a2, b1, b2;
  } pair_t;

  typedef struct {
    int            first;
    logic          same;
    logic [AW-1:0] ln;
    int            eff;
    logic [31:0]   er;
    logic          eo;
  } run_t;

  pair_t pairs [0:7];
  run_t  runs  [0:6];

  task automatic wr(input int a, input logic [31:0] din, input logic [31:0] dw);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_in   = din;
    wr_w    = dw;
  endtask

  task automatic load_run(input int r);
    pair_t p;
    for (int k = 0; k < runs[r].eff; k++) begin
      p = runs[r].same ? pairs[runs[r].first] : pairs[runs[r].first + k];
      wr(2 * k, p.a1, p.b1);
      wr(2 * k + 1, p.a2, p.b2);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_run(input int id, input logic [AW-1:0] ln, input int eff,
                        input logic [31:0] er, input logic eo);
    int c, n_en, first_en, last_en, done_at;
    n_en = 0; first_en = -1; last_en = -1; done_at = -1;
    @(negedge clk);
    len   = ln;
    start = 1'b1;
    c     = cyc;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("run%0d busy_after_start", id), 32'(busy), 32'd1);
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      if (pe_bus.pe_en) begin
        n_en++;
        if (first_en < 0) first_en = cyc - c;
        last_en = cyc - c;
      end
      if (done) done_at = cyc - c;
      else @(negedge clk);
    end
    check($sformatf("run%0d pe_en_count", id), 32'(n_en), 32'(eff));
    check($sformatf("run%0d first_pe_en", id), 32'(first_en), 32'd1);
    check($sformatf("run%0d last_pe_en", id), 32'(last_en), 32'(eff));
    check($sformatf("run%0d done_latency", id), 32'(done_at), 32'(eff + PE_LAT + 1));
    check($sformatf("run%0d result", id), result, er);
    check($sformatf("run%0d ovf", id), 32'(ovf), 32'(eo));
    check($sformatf("run%0d busy_at_done", id), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, nd, da;

    pairs[0] = '{ONE, ONE, ONE, ONE};
    pairs[1] = '{PI, PI, ONE, ONE};
    pairs[2] = '{ONE, TWO, ONE, ONE};
    pairs[3] = '{NTWO, NTHREE, ONE, ONE};
    pairs[4] = '{HALF, HALF, ONE, ONE};
    pairs[5] = '{32'h8000_0001, 32'h0, 32'h0000_0001, 32'h0};
    pairs[6] = '{MAXV, MAXV, MAXV, MAXV};
    pairs[7] = '{NMAXV, NMAXV, MAXV, MAXV};

    runs[0] = '{0, 1'b1, 4'd1, 1, 32'h0010_0000, 1'b0};
    runs[1] = '{1, 1'b1, 4'd8, 8, 32'h0192_1FB0, 1'b0};
    runs[2] = '{2, 1'b0, 4'd3, 3, 32'h8008_0000, 1'b0};
    runs[3] = '{5, 1'b1, 4'd0, 1, 32'h0000_0000, 1'b0};
    runs[4] = '{6, 1'b1, 4'd4, 4, 32'h7FFF_FFFF, 1'b1};
    runs[5] = '{7, 1'b1, 4'd2, 2, 32'hFFFF_FFFF, 1'b1};
    runs[6] = '{0, 1'b1, 4'd1, 1, 32'h0010_0000, 1'b0};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_in = '0; wr_w = '0; len = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset pe_en", 32'(pe_bus.pe_en), 32'd0);
    check("reset pe_in1", pe_bus.pe_in1, 32'd0);
    check("reset pe_in2", pe_bus.pe_in2, 32'd0);
    check("reset pe_w1", pe_bus.pe_w1, 32'd0);
    check("reset pe_w2", pe_bus.pe_w2, 32'd0);
    rst = 1'b1;

    for (int r = 0; r < 7; r++) begin
      load_run(r);
      do_run(r, runs[r].ln, runs[r].eff, runs[r].er, runs[r].eo);
    end

    // start held through the whole run and the done cycle; write attempted while busy
    @(negedge clk);
    len = 4'd1; start = 1'b1; c = cyc; nd = 0; da = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_in = MAXV; wr_w = MAXV;
      end
      if (i == 3) wr_en = 1'b0;
      if (done) begin
        nd++;
        if (da < 0) da = cyc - c;
      end
    end
    check("held_start busy_after_done", 32'(busy), 32'd0);
    start = 1'b0;
    check("held_start done_count", 32'(nd), 32'd1);
    check("held_start done_latency", 32'(da), 32'(1 + PE_LAT + 1));
    check("held_start result", result, 32'h0010_0000);
    do_run(7, 4'd1, 1, 32'h0010_0000, 1'b0);

    // reset in DRAIN aborts the run without a done pulse
    @(negedge clk);
    len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort in_drain busy", 32'(busy), 32'd1);
    check("abort in_drain pe_en", 32'(pe_bus.pe_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    check("abort pe_en", 32'(pe_bus.pe_en), 32'd0);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no_done", 32'(nd), 32'd0);
    do_run(8, 4'd1, 1, 32'h0010_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Initiator side of the two-input processing-element interface (en, in1, in2, w1, w2 → out).
- Buffers an input vector and a weight vector, issues them to one PE as element pairs (one pair per cycle), and tracks the PE's fixed pipeline latency.
- Accumulates the returned partial sums into a single saturated dot-product result.
- Sits between the layer controller (loads vectors, pulses start) and a PE instance.

Parameters:
- N, 32, word width; fixed-point sign-magnitude (bit N-1 = sign).
- Q, 19, fractional bits; must match the attached PE.
- DEPTH, 16, buffer entries per vector; even, ≥2.
- AW, $clog2(DEPTH), address width.
- PE_LAT, 3, clk cycles from the PE sampling en=1 to the matching out being valid; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  1  load strobe; write one buffer entry.
- wr_addr  in  AW  buffer index.
- wr_in  in  N  input element.
- wr_w  in  N  weight element.
- len  in  AW  number of pairs to process (1..DEPTH/2); sampled at start.
- start  in  1  begin run; ignored unless state is IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  N  sign-magnitude accumulated dot product; held until the next accepted start.
- ovf  out  1  sticky per run; set if accumulation saturated.
- pe_en  out  1  issue strobe to the PE.
- pe_in1, pe_in2  out  N  buffer inputs [2k], [2k+1].
- pe_w1, pe_w2  out  N  buffer weights [2k], [2k+1].
- pe_out  in  N  PE result (sign-magnitude).

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: state=IDLE, busy=0, done=0, result=0, ovf=0, pe_en=0, pe_* data=0.
  - Internals: latency pipe cleared, accumulator=0.
  - Buffer contents are not cleared.
  - Reset mid-run aborts the run; no done pulse is produced.
- Loading:
  - Accepted in IDLE and DONE only; wr_en is ignored while busy.
  - Writes land on the clk edge.
- State IDLE:
  - start=1 → ISSUE.
  - On that edge: latch len (len=0 is treated as 1), clear the pair index k, the accumulator and ovf.
- State ISSUE:
  - Each cycle drive pe_en=1 with pair k, then k++.
  - Exactly len consecutive pe_en cycles; no bubbles.
  - After the last pair → DRAIN.
- Latency pipe:
  - PE_LAT-deep valid shift register, fed by pe_en.
  - Its tail marks the cycle in which pe_out is sampled into the accumulator.
- State DRAIN:
  - Waits until all issued pairs have returned, i.e. pipe empty and last result accumulated → DONE.
  - Last capture occurs PE_LAT cycles after the last pe_en.
- State DONE:
  - Lasts one cycle: done=1, result updated, busy=0.
  - Next state is IDLE.
  - A start in this cycle is ignored.
- Latency:
  - Accepted start at edge t → first pe_en in cycle t+1.
  - done in cycle t + len + PE_LAT + 1.
- Arithmetic:
  - pe_out is converted sign-magnitude → two's complement and added in an N+1-bit accumulator.
  - Saturate to ±(2^(N-1)-1) and set ovf on overflow.
  - Convert back to sign-magnitude for result.
  - -0 input is treated as 0; result is never -0.
- Simultaneous events: rst has priority over start and wr_en.

Decomposition:
- Shared package (fixed-point defaults shared with the PE and multiplier/adder blocks):
  - N and Q defaults.
  - sm_to_tc / tc_to_sm conversion functions.
  - Saturation limits.
  - State encoding (IDLE, ISSUE, DRAIN, DONE).
- One natural sub-module: pe_lat_tracker, the PE_LAT valid shift register with an empty flag.

Test Plan:
- Basic pair: buffer[0..1] in=1.0 (0x00080000), w=1.0; len=1 → one pe_en cycle; done at t+5 (PE_LAT=3); result=0x00100000; ovf=0.
- Full vector: DEPTH=16, all in=π (0x001921FB), w=1.0 (0x00080000), len=8.
  - Expect 8 back-to-back pe_en cycles.
  - Expect result = 16π per the bench's reference model of the PE output format.
  - done exactly at t+12.
- Signed mix: pairs giving PE outputs +3.0, -5.0 (0x80280000), +1.0 → result = 0x80080000 (-1.0); the -0 case yields 0x00000000.
- Saturation: 4 pairs each returning 0x7FFFFFFF → result=0x7FFFFFFF, ovf=1; the next run clears ovf.
- Control corner cases:
  - start while busy is ignored.
  - wr_en while busy leaves the buffer unchanged.
  - rst=0 mid-DRAIN → all outputs 0 next cycle, no done.
  - A new run then completes correctly using the retained buffer.
